// File: rtl/axilite_pkg.sv
// axilite_pkg: AXI4-Lite response codes and the CSR read-path state type,
// shared by the CSR read and write responders.
package axilite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t AXI_RESP_OKAY   = 2'd0;
   localparam resp_t AXI_RESP_SLVERR = 2'd2;

   // ST_DECODE is only entered when AXILITE_CSR_READ_PIPE_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_RESP   = 2'd2
   } rd_state_t;

endpackage : axilite_pkg

// File: rtl/axilite_csr_addr_decode.sv
// axilite_csr_addr_decode: turns an AXI byte address into a CSR word index
// plus an out-of-range flag. Purely combinational; the low byte-lane bits are
// ignored, so unaligned addresses hit the word that contains them.
module axilite_csr_addr_decode #(
   parameter int ADDR_SIZE  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 4,
   parameter int IDX_W      = 2
) (
   input  logic [ADDR_SIZE-1:0] addr,
   output logic [IDX_W-1:0]     index,
   output logic                 out_of_range
);

   localparam int OFS = $clog2(DATA_WIDTH / 8);

   logic [ADDR_SIZE-1:0] word_addr;

   // Range check uses the full-width word address so that high address bits
   // can never alias back into the register window.
   always_comb begin
      word_addr    = addr >> OFS;
      index        = word_addr[IDX_W-1:0];
      out_of_range = (word_addr >= ADDR_SIZE'(NUM_WORDS));
   end

endmodule : axilite_csr_addr_decode

// File: rtl/axilite_csr_read_data.sv
// axilite_csr_read_data: AXI4-Lite read responder for the CSR block.
// One outstanding read; the addressed word is snapshotted into rdata so later
// changes to regs never disturb a pending response. Out-of-range reads return
// zero with SLVERR and do not pulse rd_strobe.
// Build option: define AXILITE_CSR_READ_PIPE_EN to insert a DECODE cycle that
// registers the index/range check ahead of the word mux (latency 2 instead of 1).
module axilite_csr_read_data
   import axilite_pkg::*;
#(
   parameter int    DATA_SIZE   = 128,
   parameter int    ADDR_SIZE   = 32,
   parameter int    DATA_WIDTH  = 32,
   parameter resp_t RESP_OKAY   = AXI_RESP_OKAY,
   parameter resp_t RESP_SLVERR = AXI_RESP_SLVERR
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [DATA_SIZE-1:0]                         regs,
   input  logic [ADDR_SIZE-1:0]                         araddr,
   input  logic                                         arvalid,
   output logic                                         arready,
   output logic [DATA_WIDTH-1:0]                        rdata,
   output logic [1:0]                                   rresp,
   output logic                                         rvalid,
   input  logic                                         rready,
   output logic                                         rd_strobe,
   output logic [$clog2(DATA_SIZE/DATA_WIDTH)-1:0]      rd_index
);

   localparam int NUM_WORDS = DATA_SIZE / DATA_WIDTH;
   localparam int IDX_W     = $clog2(NUM_WORDS);

   rd_state_t             state;
   logic [IDX_W-1:0]      dec_index;
   logic                  dec_oor;
   logic [IDX_W-1:0]      mux_index;
   logic [DATA_WIDTH-1:0] word_sel;

   axilite_csr_addr_decode #(
      .ADDR_SIZE  (ADDR_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (NUM_WORDS),
      .IDX_W      (IDX_W)
   ) u_addr_decode (
      .addr         (araddr),
      .index        (dec_index),
      .out_of_range (dec_oor)
   );

`ifdef AXILITE_CSR_READ_PIPE_EN
   logic [IDX_W-1:0] idx_q;
   logic             oor_q;
   assign mux_index = idx_q;
`else
   assign mux_index = dec_index;
`endif

   assign word_sel = regs[mux_index*DATA_WIDTH +: DATA_WIDTH];

   // Read FSM: AR acceptance, optional decode stage, and R channel hold until rready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         arready   <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
         rd_strobe <= 1'b0;
         rd_index  <= '0;
`ifdef AXILITE_CSR_READ_PIPE_EN
         idx_q     <= '0;
         oor_q     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the
         // pre-edge values and the default below is simply overridden.
         rd_strobe <= 1'b0;
         case (state)
            ST_IDLE: begin
               arready <= 1'b1;
               if (arvalid && arready) begin
                  arready <= 1'b0;
`ifdef AXILITE_CSR_READ_PIPE_EN
                  idx_q   <= dec_index;
                  oor_q   <= dec_oor;
                  state   <= ST_DECODE;
`else
                  rvalid    <= 1'b1;
                  rdata     <= dec_oor ? '0 : word_sel;
                  rresp     <= dec_oor ? RESP_SLVERR : RESP_OKAY;
                  rd_strobe <= !dec_oor;
                  rd_index  <= dec_index;
                  state     <= ST_RESP;
`endif
               end
            end
`ifdef AXILITE_CSR_READ_PIPE_EN
            ST_DECODE: begin
               rvalid    <= 1'b1;
               rdata     <= oor_q ? '0 : word_sel;
               rresp     <= oor_q ? RESP_SLVERR : RESP_OKAY;
               rd_strobe <= !oor_q;
               rd_index  <= idx_q;
               state     <= ST_RESP;
            end
`endif
            ST_RESP: begin
               if (rready) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state   <= ST_IDLE;
               arready <= 1'b0;
               rvalid  <= 1'b0;
            end
         endcase
      end
   end

endmodule : axilite_csr_read_data

// File: tb/tb_axilite_csr_read_data.sv
// tb_axilite_csr_read_data: directed bench for the CSR AXI4-Lite read responder.
module tb_axilite_csr_read_data;

`ifdef AXILITE_CSR_READ_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] regs;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready;
   logic         rd_strobe;
   logic [1:0]   rd_index;

   int n_checks = 0;
   int n_fails  = 0;

   axilite_csr_read_data dut (
      .clk       (clk),
      .rst       (rst),
      .regs      (regs),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .rd_strobe (rd_strobe),
      .rd_index  (rd_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an address, wait (bounded) for arready, complete the handshake,
   // then advance to the first cycle in which rvalid should be visible.
   task automatic ar_handshake(input logic [31:0] addr, input bit hold);
      int n = 0;
      araddr  = addr;
      arvalid = 1'b1;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      check("ar_wait", arready, 1'b1);
      tick();
      if (!hold) arvalid = 1'b0;
      repeat (LAT - 1) tick();
   endtask

   task automatic finish_read(input string tag);
      rready = 1'b1;
      tick();
      check({tag, "_rvalid_low"}, rvalid, 1'b0);
      check({tag, "_arready_high"}, arready, 1'b1);
      rready = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      regs    = '0;
      araddr  = '0;
      arvalid = 1'b0;
      rready  = 1'b1;
      regs[0  +: 32] = 32'hA5A5_0000;
      regs[32 +: 32] = 32'hDEAD_BEEF;
      regs[64 +: 32] = 32'h1234_5678;
      regs[96 +: 32] = 32'hCAFE_F00D;

      // Reset state
      tick();
      tick();
      check("rst_arready", arready, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_rresp", rresp, 2'd0);
      check("rst_strobe", rd_strobe, 1'b0);
      rst    = 1'b1;
      rready = 1'b0;
      tick();
      check("post_rst_arready", arready, 1'b1);

      // In-range read of word 1
      ar_handshake(32'h4, 1'b0);
      check("w1_rvalid", rvalid, 1'b1);
      check("w1_rdata", rdata, 32'hDEAD_BEEF);
      check("w1_rresp", rresp, 2'd0);
      check("w1_strobe", rd_strobe, 1'b1);
      check("w1_index", rd_index, 2'd1);
      check("w1_arready", arready, 1'b0);
      tick();
      check("w1_strobe_one_cycle", rd_strobe, 1'b0);
      check("w1_rvalid_sticky", rvalid, 1'b1);
      finish_read("w1");

      // Unaligned address hits the containing word
      ar_handshake(32'h6, 1'b0);
      check("unal_rdata", rdata, 32'hDEAD_BEEF);
      check("unal_rresp", rresp, 2'd0);
      check("unal_index", rd_index, 2'd1);
      finish_read("unal");

      // First out-of-range word
      ar_handshake(32'h10, 1'b0);
      check("oor_rvalid", rvalid, 1'b1);
      check("oor_rresp", rresp, 2'd2);
      check("oor_rdata", rdata, 32'h0);
      check("oor_strobe", rd_strobe, 1'b0);
      finish_read("oor");

      // High address bits must not alias into the window
      ar_handshake(32'h8000_0004, 1'b0);
      check("alias_rresp", rresp, 2'd2);
      check("alias_rdata", rdata, 32'h0);
      check("alias_strobe", rd_strobe, 1'b0);
      finish_read("alias");

      // Backpressure with regs changing underneath
      ar_handshake(32'h8, 1'b0);
      for (int i = 0; i < 5; i++) begin
         regs[64 +: 32] = 32'h1000_0000 + 32'(i);
         tick();
         check("bp_rvalid", rvalid, 1'b1);
         check("bp_rdata", rdata, 32'h1234_5678);
         check("bp_arready", arready, 1'b0);
      end
      finish_read("bp");

      // Back-to-back reads with arvalid held and rready high
      rready = 1'b1;
      ar_handshake(32'h0, 1'b1);
      check("b2b0_rvalid", rvalid, 1'b1);
      check("b2b0_rdata", rdata, 32'hA5A5_0000);
      check("b2b0_arready", arready, 1'b0);
      araddr = 32'h8;
      tick();
      check("b2b_U_rvalid", rvalid, 1'b0);
      check("b2b_U_arready", arready, 1'b1);
      tick();
      arvalid = 1'b0;
      repeat (LAT - 1) tick();
      check("b2b1_rvalid", rvalid, 1'b1);
      check("b2b1_rdata", rdata, 32'h1000_0004);
      check("b2b1_index", rd_index, 2'd2);
      tick();
      check("b2b1_done", rvalid, 1'b0);
      rready = 1'b0;
      tick();

      // Asynchronous reset while a response is pending
      ar_handshake(32'h4, 1'b0);
      check("mid_rvalid_before", rvalid, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rvalid_async", rvalid, 1'b0);
      check("mid_arready_async", arready, 1'b0);
      check("mid_rdata_async", rdata, 32'h0);
      check("mid_strobe_async", rd_strobe, 1'b0);
      tick();
      tick();
      rst    = 1'b1;
      rready = 1'b1;
      tick();
      check("mid_post_arready", arready, 1'b1);
      check("mid_post_rvalid", rvalid, 1'b0);
      tick();
      check("mid_no_resp", rvalid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule : tb_axilite_csr_read_data

// File: doc/axilite_csr_read_data.md
# axilite_csr_read_data

AXI4-Lite read-side responder for the CSR block: accepts read addresses on the AR channel, returns one DATA_WIDTH-bit word from the flat `regs` vector on the R channel, and flags out-of-range reads with SLVERR. It pairs with the CSR write-data path, which owns and updates `regs`. It holds at most one outstanding read and snapshots the addressed word at address acceptance.

## Interface
- DATA_SIZE, 128: total CSR bits in `regs`; multiple of DATA_WIDTH.
- ADDR_SIZE, 32: AXI address width.
- DATA_WIDTH, 32: AXI data width (32 or 64).
- RESP_OKAY, 0: response code for in-range reads.
- RESP_SLVERR, 2: response code for out-of-range reads.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- regs  in  DATA_SIZE  CSR contents; word k is regs[k*DATA_WIDTH +: DATA_WIDTH].
- araddr  in  ADDR_SIZE  read byte address.
- arvalid  in  1  address valid.
- arready  out  1  address accepted when arvalid && arready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  master ready for data.
- rd_strobe  out  1  one-cycle pulse per accepted in-range read (for read side effects).
- rd_index  out  $clog2(DATA_SIZE/DATA_WIDTH)  word index of the read; valid while rd_strobe is high.

## Operation
- Reset values: arready=0, rvalid=0, rdata=0, rresp=RESP_OKAY, rd_strobe=0, rd_index=0, state=IDLE.
- Decode: low $clog2(DATA_WIDTH/8) address bits ignored (aligned); index = araddr >> that count; out of range if index >= DATA_SIZE/DATA_WIDTH (compare the full-width index, no truncation).
- States: IDLE, (DECODE under macro), RESP.
- IDLE: arready=1. On arvalid: capture address. Without macro, go to RESP with rdata=regs word (or 0 if out of range) and rresp=RESP_OKAY or RESP_SLVERR.
- RESP: arready=0, rvalid=1; rdata/rresp held stable until rready. On rready: rvalid→0, go to IDLE.
- rd_strobe pulses in the first cycle of RESP only for in-range reads; rd_index = captured index.
- Data snapshot: rdata reflects regs at the capture edge; later regs changes do not alter a pending response.
- Throughput: one read per 2 cycles minimum (3 with macro); arready is never high while rvalid is high.

## Timing
- AR handshake at edge T → rvalid high after edge T+1 (macro off) or T+2 (macro on).
- rvalid && rready at edge U → rvalid low and arready high after U; the next AR handshake is possible at edge U+1.
- arready deasserts the cycle after the AR handshake; arvalid low in IDLE causes no change.
- Asynchronous reset mid-transaction: all outputs immediately go to reset values; the pending response is dropped; arready rises on the first clock after reset release.
- The block honours rvalid stickiness: it never drops rvalid without rready.

## Configuration
- AXILITE_CSR_READ_PIPE_EN: defined → adds a DECODE state that registers the index and range check before the word mux, so RESP follows DECODE one cycle later (latency 2, for timing closure on wide DATA_SIZE). Undefined → decode and mux complete in the capture cycle (latency 1). Response values and handshake rules are identical in both builds.

## Structure
- Package axilite_pkg: RESP_* codes, 2-bit resp type, read state enum, shared with the write path.
- Sub-module axilite_csr_addr_decode: combinational align/index/out-of-range logic, reused by the write path.

## Test plan
- Reset: rst low with rready=1 → arready=0, rvalid=0, rdata=0; after release arready=1.
- In-range read: regs word1=0xDEADBEEF, araddr=0x4 → rdata=0xDEADBEEF, rresp=0, rvalid at T+1 (T+2 with macro), rd_strobe=1 for one cycle with rd_index=1.
- Unaligned/out-of-range: araddr=0x6 → word1 OKAY; araddr=0x10 (DATA_SIZE=128) → rresp=2, rdata=0, no rd_strobe.
- Backpressure: rready=0 for 5 cycles, regs changing → rvalid held, rdata keeps the snapshot, arready=0 throughout.
- Back-to-back: arvalid held with addresses 0x0 and 0x8, rready=1 → two responses, second AR handshake at U+1.
- Reset mid-RESP: assert rst while rvalid=1 → rvalid=0 asynchronously, no response completes after release.
